fpga_exp2_scan: RTL and testbench
=================================

# fpga_exp2_scan

Upstream sequencer for the 1-to-8 4-bit demultiplexer stage. It accepts 4-bit data words over a valid/ready handshake and selects a target channel, either auto-incrementing or explicit. It then drives the demux `en`/`data4`/`cs` inputs with a settle-then-hold sequence, so each word lands cleanly on exactly one of `dout0..dout7`. It also flags completion of each full 8-channel scan frame.

## Interface
- `HOLD`, default 2: cycles `en` stays high per word; legal range 1..15.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_data`  in  4  data word to distribute.
- `in_valid`  in  1  `in_data`/`in_ch` valid.
- `in_ready`  out  1  block can accept a word this cycle.
- `mode`  in  1  0 = auto-increment channel pointer; 1 = use `in_ch`.
- `in_ch`  in  3  explicit target channel, used when `mode`=1.
- `ch_clr`  in  1  forces auto pointer to 0.
- `en`  out  1  demux enable.
- `data4`  out  4  demux data.
- `cs`  out  3  demux channel select.
- `frame_done`  out  1  one-cycle pulse when channel 7 is written in auto mode.

## Operation
- States: IDLE, SETUP, DRIVE.
- **IDLE**
  - `in_ready`=1, `en`=0.
  - `in_valid`&`in_ready` accepts the word: capture `in_data` into `data4`.
  - `cs` is loaded from `in_ch` if `mode`=1, else from the auto pointer.
  - `mode` is sampled at accept and is fixed for that word.
  - Go to SETUP.
- **SETUP** (1 cycle)
  - `cs`/`data4` are stable and `en`=0 (address settle); `in_ready`=0.
  - Load hold counter with `HOLD`-1. Go to DRIVE.
- **DRIVE** (`HOLD` cycles)
  - `en`=1, `cs`/`data4` unchanged, `in_ready`=0.
  - When the counter reaches 0, go to IDLE with `en`=0.
  - On that exit, if the word was auto mode, the pointer increments mod 8 (7 wraps to 0).
- **Auto pointer**
  - Reset value 0. Explicit-mode words do not move it.
- **ch_clr**
  - Clears the pointer in any state and has priority over the increment.
  - If asserted in the same cycle as an auto-mode accept, that word uses channel 0 and the pointer then advances to 1 on exit.
  - If asserted during SETUP/DRIVE, the in-flight word completes on its captured channel and the pointer ends at 0.
- **frame_done**
  - Pulses high for the last DRIVE cycle of an auto-mode word whose `cs`=7.
  - Never pulses for explicit-mode words, including when `in_ch`=7.
- `data4` and `cs` hold their last values in IDLE until the next accept. The demux ignores them because `en`=0.

## Timing
- All outputs are registered.
- Reset values: `en`=0, `data4`=0, `cs`=0, `in_ready`=0, `frame_done`=0, state IDLE, pointer 0.
- `in_ready` rises on the first clock after `rst` deasserts.
- Accept at edge N gives:
  - `cs`/`data4` valid from N+1;
  - `en` high for cycles N+2 .. N+1+`HOLD`;
  - `in_ready` high again at N+2+`HOLD`.
- Throughput: one word per `HOLD`+2 cycles. `in_valid` held continuously gives back-to-back words with exactly one IDLE cycle between them, during which `en`=0.
- `in_data`/`in_ch` may change freely when `in_ready`=0; they are ignored.
- `rst` mid-word: the next cycle is in reset state, `en` drops immediately, and the word is dropped with no `frame_done`.
- `en` never goes high in the same cycle that `cs` changes.

## Test plan
- **Reset**: hold `rst` 3 cycles with `in_valid`=1.
  - All outputs 0 during reset; `in_ready`=1 one cycle after release.
- **Auto scan**: `HOLD`=2, `mode`=0, stream `data4`=0 then 15 for 8 words each.
  - `cs` steps 0..7 twice; `en` high 2 cycles per word.
  - `frame_done` pulses exactly twice, on the last `en` cycle of `cs`=7.
  - Throughput is one word per 4 cycles.
- **Explicit select**: `mode`=1, send `in_ch`=5, 5, 2 with data 4'hA, 4'h3, 4'hC.
  - `cs`=5, 5, 2 with matching `data4`; no `frame_done`; auto pointer remains 0.
- **Clear collision**:
  - After 3 auto words, assert `ch_clr` with the 4th accept: the word goes to `cs`=0 and the next auto word goes to `cs`=1.
  - Assert `ch_clr` mid-DRIVE of a `cs`=6 word: the word finishes on 6 and the next word goes to `cs`=0.
- **Mid-word reset and settle check**: pulse `rst` during DRIVE.
  - `en`=0 the next cycle; no `frame_done`; the following word goes to `cs`=0.
  - A checker confirms `cs`/`data4` are stable across every `en`-high window and that `en`=0 in every cycle where `cs` changes.

Source files
------------

// File: rtl/fpga_exp2_scan.sv
// Sequencer for a 1-to-8 4-bit demux. It accepts words over valid/ready, then drives
// cs/data4 with a one-cycle address settle before holding en high for HOLD cycles.
module fpga_exp2_scan #(
    parameter int HOLD = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       mode,
    input  logic [2:0] in_ch,
    input  logic       ch_clr,
    output logic       en,
    output logic [3:0] data4,
    output logic [2:0] cs,
    output logic       frame_done
);

    typedef enum logic [1:0] {IDLE, SETUP, DRIVE} state_t;

    state_t     state, state_next;
    logic [3:0] cnt, cnt_next;
    logic [2:0] ptr, ptr_next;
    logic       word_auto, word_auto_next;
    logic       clr_seen, clr_seen_next;
    logic [3:0] data4_next;
    logic [2:0] cs_next;
    logic       en_next, in_ready_next, frame_done_next;
    logic       drive_exit;

    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        ptr_next       = ptr;
        word_auto_next = word_auto;
        clr_seen_next  = clr_seen;
        data4_next     = data4;
        cs_next        = cs;
        drive_exit     = 1'b0;

        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    data4_next     = in_data;
                    cs_next        = mode ? in_ch : (ch_clr ? 3'd0 : ptr);
                    word_auto_next = ~mode;
                    clr_seen_next  = 1'b0;
                    state_next     = SETUP;
                end
            end
            SETUP: begin
                cnt_next   = 4'(HOLD - 1);
                state_next = DRIVE;
            end
            DRIVE: begin
                if (cnt == 4'd0) begin
                    drive_exit = 1'b1;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            default: state_next = IDLE;
        endcase

        // A clear seen while a word is in flight must win over that word's increment at exit.
        if (state != IDLE && ch_clr) clr_seen_next = 1'b1;
        if (drive_exit && word_auto && !clr_seen) ptr_next = ptr + 3'd1;
        if (ch_clr) ptr_next = 3'd0;

        en_next         = (state_next == DRIVE);
        in_ready_next   = (state_next == IDLE);
        frame_done_next = (state_next == DRIVE) && (cnt_next == 4'd0) && word_auto && (cs == 3'd7);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            ptr        <= 3'd0;
            word_auto  <= 1'b0;
            clr_seen   <= 1'b0;
            data4      <= 4'd0;
            cs         <= 3'd0;
            en         <= 1'b0;
            in_ready   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            ptr        <= ptr_next;
            word_auto  <= word_auto_next;
            clr_seen   <= clr_seen_next;
            data4      <= data4_next;
            cs         <= cs_next;
            en         <= en_next;
            in_ready   <= in_ready_next;
            frame_done <= frame_done_next;
        end
    end

endmodule

// File: tb/tb_fpga_exp2_scan.sv
// Directed bench for fpga_exp2_scan: word timeline, pointer/clear behaviour, frame pulses
// and a background monitor that en never overlaps a cs/data4 change.
module tb_fpga_exp2_scan;

    localparam int HOLD = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       mode;
    logic [2:0] in_ch;
    logic       ch_clr;
    logic       en;
    logic [3:0] data4;
    logic [2:0] cs;
    logic       frame_done;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int fd_cnt = 0;
    int settle_viol = 0;
    logic [2:0] prev_cs;
    logic [3:0] prev_data4;

    fpga_exp2_scan #(.HOLD(HOLD)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .in_ch(in_ch), .ch_clr(ch_clr), .en(en), .data4(data4), .cs(cs),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (frame_done === 1'b1) fd_cnt++;
        if (en === 1'b1 && (cs !== prev_cs || data4 !== prev_data4)) settle_viol++;
        prev_cs    = cs;
        prev_data4 = data4;
    end

    task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Entered and left on a falling edge; sends one word and checks its whole timeline.
    task automatic applyStimulus(input logic [3:0] d, input logic m, input logic [2:0] ch,
                                 input logic clr_acc, input logic clr_mid,
                                 input logic [2:0] exp_cs, input logic exp_fd);
        int waitc = 0;
        while (in_ready !== 1'b1 && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        checkOutput("ready_wait", 8'(in_ready), 8'd1);
        in_data  = d;
        mode     = m;
        in_ch    = ch;
        ch_clr   = clr_acc;
        in_valid = 1'b1;
        @(negedge clk);
        acc_cyc  = cyc;
        in_valid = 1'b0;
        ch_clr   = 1'b0;
        in_data  = ~d;
        in_ch    = ~ch;
        checkOutput("setup_en", 8'(en), 8'd0);
        checkOutput("setup_ready", 8'(in_ready), 8'd0);
        checkOutput("setup_cs", 8'(cs), 8'(exp_cs));
        checkOutput("setup_data", 8'(data4), 8'(d));
        for (int i = 0; i < HOLD; i++) begin
            @(negedge clk);
            ch_clr = 1'b0;
            checkOutput("drive_en", 8'(en), 8'd1);
            checkOutput("drive_cs", 8'(cs), 8'(exp_cs));
            checkOutput("drive_data", 8'(data4), 8'(d));
            checkOutput("drive_fd", 8'(frame_done), 8'((exp_fd && i == HOLD - 1) ? 1 : 0));
            if (clr_mid && i == 0) ch_clr = 1'b1;
        end
        @(negedge clk);
        ch_clr = 1'b0;
        checkOutput("exit_en", 8'(en), 8'd0);
        checkOutput("exit_ready", 8'(in_ready), 8'd1);
        checkOutput("exit_fd", 8'(frame_done), 8'd0);
    endtask

    initial begin
        int t0;
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 4'h9;
        mode     = 1'b0;
        in_ch    = 3'd3;
        ch_clr   = 1'b0;

        // reset held three cycles with a word offered
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("rst_en", 8'(en), 8'd0);
            checkOutput("rst_data", 8'(data4), 8'd0);
            checkOutput("rst_cs", 8'(cs), 8'd0);
            checkOutput("rst_ready", 8'(in_ready), 8'd0);
            checkOutput("rst_fd", 8'(frame_done), 8'd0);
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_ready", 8'(in_ready), 8'd1);
        checkOutput("post_rst_en", 8'(en), 8'd0);

        // auto scan: two full frames, back to back
        t0 = 0;
        for (int i = 0; i < 16; i++) begin
            applyStimulus((i < 8) ? 4'h0 : 4'hF, 1'b0, 3'd0, 1'b0, 1'b0, 3'(i % 8), (i % 8) == 7);
            if (i == 0) t0 = acc_cyc;
        end
        checkOutput("scan_cycles", 8'(acc_cyc - t0), 8'(15 * (HOLD + 2)));
        checkOutput("scan_frames", 8'(fd_cnt), 8'd2);

        // explicit select leaves the pointer alone and never flags a frame
        applyStimulus(4'hA, 1'b1, 3'd5, 1'b0, 1'b0, 3'd5, 1'b0);
        applyStimulus(4'h3, 1'b1, 3'd5, 1'b0, 1'b0, 3'd5, 1'b0);
        applyStimulus(4'hC, 1'b1, 3'd2, 1'b0, 1'b0, 3'd2, 1'b0);
        applyStimulus(4'h6, 1'b1, 3'd7, 1'b0, 1'b0, 3'd7, 1'b0);
        applyStimulus(4'h1, 1'b0, 3'd4, 1'b0, 1'b0, 3'd0, 1'b0);

        // clear coinciding with an accept
        applyStimulus(4'h2, 1'b0, 3'd0, 1'b0, 1'b0, 3'd1, 1'b0);
        applyStimulus(4'h3, 1'b0, 3'd0, 1'b0, 1'b0, 3'd2, 1'b0);
        applyStimulus(4'h4, 1'b0, 3'd0, 1'b0, 1'b0, 3'd3, 1'b0);
        applyStimulus(4'h5, 1'b0, 3'd0, 1'b1, 1'b0, 3'd0, 1'b0);
        applyStimulus(4'h6, 1'b0, 3'd0, 1'b0, 1'b0, 3'd1, 1'b0);

        // clear in the middle of a cs=6 word
        for (int c = 2; c < 6; c++) applyStimulus(4'(c), 1'b0, 3'd0, 1'b0, 1'b0, 3'(c), 1'b0);
        applyStimulus(4'hE, 1'b0, 3'd0, 1'b0, 1'b1, 3'd6, 1'b0);
        applyStimulus(4'h7, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0);

        // walk pointer to 7, then reset in the middle of that word
        for (int c = 1; c < 7; c++) applyStimulus(4'(c + 8), 1'b0, 3'd0, 1'b0, 1'b0, 3'(c), 1'b0);
        in_data  = 4'hD;
        mode     = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("rw_setup_cs", 8'(cs), 8'd7);
        @(negedge clk);
        checkOutput("rw_drive_en", 8'(en), 8'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rw_en", 8'(en), 8'd0);
        checkOutput("rw_fd", 8'(frame_done), 8'd0);
        checkOutput("rw_ready", 8'(in_ready), 8'd0);
        @(negedge clk);
        checkOutput("rw_ready_back", 8'(in_ready), 8'd1);
        applyStimulus(4'hB, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0);

        checkOutput("frames_total", 8'(fd_cnt), 8'd2);
        checkOutput("settle", 8'(settle_viol), 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
